pipeline_ctrl: RTL and testbench

Parametrised pipeline control block for the in-order RISC-V core. It replaces the fixed 5-stage hazard and forwarding logic with a scoreboard that shadows DEPTH post-decode stages, where stage 0 is EX and stage DEPTH-1 is WB. Each cycle it generates:
- load-use stall,
- redirect flush,
- forwarding selects for the EX operands,
- pipeline-wide freeze,
- saturating stall and flush counters.

It sits beside the datapath and drives the PC, IF/ID and ID/EX register enables and the operand muxes.

---
 rtl/pipeline_ctrl_if.sv | 49 ++++
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the in-order datapath and pipeline_ctrl.
// Latency: n/a (wires only).
// Backpressure: ext_stall from the datapath freezes the controller.
interface pipeline_ctrl_if #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Decode-stage instruction description
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  // Global pipeline events
  logic              ext_stall;
  logic              redirect;
  // Register enables and operand selects back to the datapath
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              lu_stall;
  logic [2:0]        fwd_a;
  logic [2:0]        fwd_b;
  logic [DEPTH-1:0]  stage_valid;
  logic              retire;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Datapath side: describes instructions, consumes enables.
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, ext_stall, redirect,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, lu_stall,
           fwd_a, fwd_b, stage_valid, retire, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, ext_stall, redirect,
    output pc_write, ifid_write, ifid_flush, idex_bubble, lu_stall,
           fwd_a, fwd_b, stage_valid, retire, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Scoreboard-based hazard/forwarding controller shadowing DEPTH post-decode stages.
// Latency: all enables and selects are combinational from the scoreboard; state advances 1/cycle.
// Backpressure: ext_stall holds every entry and counter and deasserts all enables.
module pipeline_ctrl #(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  // Per-stage scoreboard; index 0 is EX, DEPTH-1 is WB
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             rw_q,  rw_d;
  logic [DEPTH-1:0]             ld_q,  ld_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q,  rd_d;
  // EX-only source operand tracking used for forwarding
  logic [REG_AW-1:0]            rs1_q, rs1_d;
  logic [REG_AW-1:0]            rs2_q, rs2_d;
  logic                         use1_q, use1_d;
  logic                         use2_q, use2_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]             flush_cnt_q, flush_cnt_d;

  logic lu_stall;
  logic redir_take;
  logic accept;

  // Load-use detection: a load younger than LOAD_LAT-1 cannot yet supply ID's sources
  always_comb begin
    lu_stall = 1'b0;
    for (int k = 0; k < LOAD_LAT - 1; k++) begin
      if (vld_q[k] && ld_q[k] && rw_q[k] && (rd_q[k] != '0) && bus.id_valid &&
          ((bus.id_use_rs1 && (rd_q[k] == bus.id_rs1)) ||
           (bus.id_use_rs2 && (rd_q[k] == bus.id_rs2)))) begin
        lu_stall = 1'b1;
      end
    end
  end

  // Register enables; an honoured redirect overrides load-use since ID is on the wrong path
  always_comb begin
    redir_take       = bus.redirect & vld_q[0] & ~bus.ext_stall;
    // Gating on the honoured redirect keeps an ignored redirect from dropping the ID instruction
    accept           = bus.id_valid & ~redir_take & ~lu_stall;
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_bubble  = 1'b0;
    if (bus.ext_stall) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
    end else if (redir_take) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (lu_stall) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end
    bus.lu_stall    = lu_stall;
    bus.stage_valid = vld_q;
    bus.retire      = vld_q[DEPTH-1] & ~bus.ext_stall;
    bus.stall_cnt   = stall_cnt_q;
    bus.flush_cnt   = flush_cnt_q;
  end

  // Forwarding selects; scanning oldest-to-youngest lets the youngest producer win
  always_comb begin
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (vld_q[0] && use1_q && vld_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rs1_q))
        bus.fwd_a = 3'(k);
      if (vld_q[0] && use2_q && vld_q[k] && rw_q[k] && (rd_q[k] != '0) && (rd_q[k] == rs2_q))
        bus.fwd_b = 3'(k);
    end
  end

  // Scoreboard shift and saturating event counters
  always_comb begin
    vld_d       = vld_q;
    rw_d        = rw_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    use1_d      = use1_q;
    use2_d      = use2_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.ext_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
        rw_d[k]  = rw_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      vld_d[0] = accept;
      rw_d[0]  = bus.id_regwrite;
      ld_d[0]  = bus.id_is_load;
      rd_d[0]  = bus.id_rd;
      rs1_d    = bus.id_rs1;
      rs2_d    = bus.id_rs2;
      use1_d   = bus.id_use_rs1;
      use2_d   = bus.id_use_rs2;
      if (redir_take) begin
        if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (lu_stall) begin
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset empties the scoreboard immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q       <= '0;
      rw_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rw_q        <= rw_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use1_q      <= use1_d;
      use2_q      <= use2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random traffic.
// Reference keeps one record per in-flight instruction and applies the hazard rules directly.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_pipeline_ctrl;
  localparam int DEPTH    = 3;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.DEPTH(DEPTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v; int rd; bit rw; bit ld; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  ins_t pipe [DEPTH];
  int   m_stall, m_flush;
  bit   e_lu, e_take, e_pc, e_ifw, e_fl, e_bub, e_ret;
  int   e_fa, e_fb;
  logic [DEPTH-1:0] e_sv;

  function automatic int fwd_src(input int r, input bit used);
    if (!pipe[0].v || !used || r == 0) return 0;
    for (int k = 1; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd == r) return k;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) pipe[k] = '{default: 0};
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic void model_eval();
    e_lu = 0;
    for (int k = 0; k < LOAD_LAT - 1; k++)
      if (pipe[k].v && pipe[k].ld && pipe[k].rw && pipe[k].rd != 0 && bus.id_valid &&
          ((bus.id_use_rs1 && pipe[k].rd == int'(bus.id_rs1)) ||
           (bus.id_use_rs2 && pipe[k].rd == int'(bus.id_rs2))))
        e_lu = 1;
    e_take = bus.redirect && pipe[0].v && !bus.ext_stall;
    if (bus.ext_stall)  begin e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; end
    else if (e_take)    begin e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1; end
    else if (e_lu)      begin e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; end
    else                begin e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; end
    e_fa = fwd_src(pipe[0].rs1, pipe[0].u1);
    e_fb = fwd_src(pipe[0].rs2, pipe[0].u2);
    for (int k = 0; k < DEPTH; k++) e_sv[k] = pipe[k].v;
    e_ret = pipe[DEPTH-1].v && !bus.ext_stall;
  endfunction

  function automatic void model_step();
    ins_t n;
    if (bus.ext_stall) return;
    n = '{default: 0};
    if (bus.id_valid && !bus.redirect && !e_lu) begin
      n.v = 1; n.rd = int'(bus.id_rd); n.rw = bus.id_regwrite; n.ld = bus.id_is_load;
      n.rs1 = int'(bus.id_rs1); n.rs2 = int'(bus.id_rs2);
      n.u1 = bus.id_use_rs1; n.u2 = bus.id_use_rs2;
    end
    for (int k = DEPTH - 1; k >= 1; k--) pipe[k] = pipe[k-1];
    pipe[0] = n;
    if (e_take) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    else if (e_lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit ld);
    bus.id_valid    = v;
    bus.id_rs1      = REG_AW'(rs1);
    bus.id_use_rs1  = u1;
    bus.id_rs2      = REG_AW'(rs2);
    bus.id_use_rs2  = u2;
    bus.id_rd       = REG_AW'(rd);
    bus.id_regwrite = rw;
    bus.id_is_load  = ld;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #1;
    model_eval();
    check("pc_write",    32'(bus.pc_write),    32'(e_pc));
    check("ifid_write",  32'(bus.ifid_write),  32'(e_ifw));
    check("ifid_flush",  32'(bus.ifid_flush),  32'(e_fl));
    check("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
    check("lu_stall",    32'(bus.lu_stall),    32'(e_lu));
    check("fwd_a",       32'(bus.fwd_a),       32'(e_fa));
    check("fwd_b",       32'(bus.fwd_b),       32'(e_fb));
    check("stage_valid", 32'(bus.stage_valid), 32'(e_sv));
    check("retire",      32'(bus.retire),      32'(e_ret));
    check("stall_cnt",   32'(bus.stall_cnt),   32'(m_stall));
    check("flush_cnt",   32'(bus.flush_cnt),   32'(m_flush));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    settle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit hold;
    reset = 1'b1;
    bus.ext_stall = 1'b0;
    bus.redirect  = 1'b0;
    nop();
    model_reset();
    @(negedge clk);
    do_reset();

    // Back-to-back ALU dependency: add x5,x1,x2 ; sub x6,x5,x3 ; use of x5
    set_id(1, 1, 1, 2, 1, 5, 1, 0); step();
    set_id(1, 5, 1, 3, 1, 6, 1, 0); step();
    set_id(1, 5, 1, 0, 0, 10, 1, 0); settle();
    check("b2b_fwd_a_stage1", 32'(bus.fwd_a), 32'd1);
    check("b2b_no_stall", 32'(bus.lu_stall), 32'd0);
    advance();
    nop(); settle();
    check("b2b_fwd_a_stage2", 32'(bus.fwd_a), 32'd2);
    advance();

    // Load-use: lw x7 ; add x8,x7,x7
    do_reset();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 7, 1, 8, 1, 0); settle();
    check("lu_stall_on", 32'(bus.lu_stall), 32'd1);
    check("lu_pc_hold", 32'(bus.pc_write), 32'd0);
    check("lu_bubble", 32'(bus.idex_bubble), 32'd1);
    advance();
    settle();
    check("lu_stall_once", 32'(bus.lu_stall), 32'd0);
    advance();
    nop(); settle();
    check("lu_fwd_a", 32'(bus.fwd_a), 32'd2);
    check("lu_fwd_b", 32'(bus.fwd_b), 32'd2);
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    advance();

    // Redirect collides with a load-use hazard
    do_reset();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 8, 1, 0);
    bus.redirect = 1'b1;
    settle();
    check("col_flush", 32'(bus.ifid_flush), 32'd1);
    check("col_bubble", 32'(bus.idex_bubble), 32'd1);
    check("col_pc_write", 32'(bus.pc_write), 32'd1);
    advance();
    bus.redirect = 1'b0;
    nop(); settle();
    check("col_ex_invalid", 32'(bus.stage_valid[0]), 32'd0);
    check("col_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("col_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    advance();

    // ext_stall for 3 cycles with a full pipe and a pending redirect
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 1, 1, 2, 1, 10 + i, 1, 0); step();
    end
    bus.ext_stall = 1'b1;
    bus.redirect  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("frz_stage_valid", 32'(bus.stage_valid), 32'h7);
      check("frz_retire", 32'(bus.retire), 32'd0);
      check("frz_no_flush", 32'(bus.ifid_flush), 32'd0);
      advance();
    end
    bus.ext_stall = 1'b0;
    settle();
    check("rel_flush", 32'(bus.ifid_flush), 32'd1);
    advance();
    bus.redirect = 1'b0;
    nop(); settle();
    check("rel_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    advance();

    // x0 and unused-source filtering
    do_reset();
    set_id(1, 1, 1, 0, 0, 0, 1, 0); step();
    set_id(1, 0, 1, 0, 1, 4, 1, 0); step();
    nop(); settle();
    check("x0_fwd_a", 32'(bus.fwd_a), 32'd0);
    check("x0_fwd_b", 32'(bus.fwd_b), 32'd0);
    advance();
    set_id(1, 1, 1, 0, 0, 9, 1, 1); step();
    set_id(1, 1, 1, 9, 0, 4, 1, 0); settle();
    check("unused_rs2_no_stall", 32'(bus.lu_stall), 32'd0);
    advance();
    nop(); step();

    // Saturation: 20 load-use stalls on a 4-bit counter, then reset mid-stall
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
      set_id(1, 7, 1, 0, 0, 8, 1, 0); step();
      step();
    end
    nop(); settle();
    check("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
    advance();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 8, 1, 0); settle();
    check("pre_rst_stall", 32'(bus.lu_stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_stage_valid", 32'(bus.stage_valid), 32'd0);
    check("rst_lu_stall", 32'(bus.lu_stall), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("rst_pc_write", 32'(bus.pc_write), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nop();

    // Random traffic against the reference model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.ext_stall = ($urandom_range(0, 9) == 0);
      if (hold) bus.redirect = 1'b1;
      else      bus.redirect = pipe[0].v && ($urandom_range(0, 5) == 0);
      hold = bus.ext_stall && bus.redirect;
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 3), $urandom_range(0, 9) < 7,
             $urandom_range(0, 3), $urandom_range(0, 9) < 7,
             $urandom_range(0, 3), $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
